// File: rtl/arq_pkg.sv
// Shared definitions for the stop-and-wait ARQ link: default payload width,
// receiver FSM states, the even-parity check and the response codes that the
// transmit FSM also decodes.
package arq_pkg;

    localparam int ARQ_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } arqRxState_t;

    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_ACK  = 2'b01;
    localparam logic [1:0] RESP_NACK = 2'b10;

    // Even parity holds when the XOR of all covered bits equals the parity bit.
    // Callers zero-extend {seq, data} into the 32-bit argument.
    function automatic logic evenParityOk(input logic [31:0] bits, input logic par);
        return (^bits) == par;
    endfunction

endpackage

// File: rtl/arq_rx_fifo.sv
// Show-ahead synchronous FIFO buffering accepted payloads for the consumer.
// Head entry is always visible on o_data; pushes when full and pops when empty
// are dropped. Full is judged on the current count, so a pop on the same edge
// never makes room for a push.
module arq_rx_fifo #(
    parameter int DATA_W    = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [DATA_W-1:0]            i_data,
    input  logic                         i_pop,
    output logic [DATA_W-1:0]            o_data,
    output logic [$clog2(OUT_DEPTH):0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [OUT_DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic              w_doPush;
    logic              w_doPop;

    assign o_full   = (r_count == CW'(OUT_DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];
    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;

    // Storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/arq_rx_receiver.sv
// Receive side of the stop-and-wait ARQ link. Latches one frame, checks parity
// and sequence, answers with a single ack or nack pulse, drops retransmitted
// duplicates and queues new payloads into a show-ahead output FIFO.
// Optional build macro ARQ_RX_STATS_EN adds saturating good_cnt / nack_cnt
// statistics outputs.
module arq_rx_receiver
    import arq_pkg::*;
#(
    parameter int DATA_W     = ARQ_DATA_W,
    parameter int OUT_DEPTH  = 4,
    parameter int NACK_LIMIT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx_valid,
    input  logic [DATA_W-1:0]            rx_data,
    input  logic                         rx_seq,
    input  logic                         rx_par,
    output logic                         ack,
    output logic                         nack,
    output logic [DATA_W-1:0]            dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [$clog2(OUT_DEPTH):0]   fifo_count,
    output logic                         link_err
`ifdef ARQ_RX_STATS_EN
    ,
    output logic [7:0]                   good_cnt,
    output logic [7:0]                   nack_cnt
`endif
);

    localparam int NW = $clog2(NACK_LIMIT + 1);

    arqRxState_t       r_state;
    logic [DATA_W-1:0] r_data;
    logic              r_seq;
    logic              r_par;
    logic              r_expectedSeq;
    logic              r_ack;
    logic              r_nack;
    logic              r_linkErr;
    logic [NW-1:0]     r_nackRun;

    logic              w_parGood;
    logic              w_seqMatch;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic [1:0]        w_respCode;

    assign w_parGood  = evenParityOk(32'({r_seq, r_data}), r_par);
    assign w_seqMatch = (r_seq == r_expectedSeq);

    // Decide the response for the latched frame while in CHECK; only a fresh,
    // clean frame with room in the FIFO is pushed.
    always_comb begin
        w_respCode = RESP_NONE;
        w_push     = 1'b0;
        if (r_state == CHECK) begin
            if (!w_parGood) begin
                w_respCode = RESP_NACK;
            end else if (!w_seqMatch) begin
                w_respCode = RESP_ACK;
            end else if (w_full) begin
                w_respCode = RESP_NACK;
            end else begin
                w_respCode = RESP_ACK;
                w_push     = 1'b1;
            end
        end
    end

    // Frame FSM with registered ack/nack pulses, expected sequence and nack-run tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_data        <= '0;
            r_seq         <= 1'b0;
            r_par         <= 1'b0;
            r_expectedSeq <= 1'b0;
            r_ack         <= 1'b0;
            r_nack        <= 1'b0;
            r_linkErr     <= 1'b0;
            r_nackRun     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rx_valid) begin
                        r_data  <= rx_data;
                        r_seq   <= rx_seq;
                        r_par   <= rx_par;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_respCode == RESP_ACK) begin
                        r_ack     <= 1'b1;
                        r_nackRun <= '0;
                    end else begin
                        r_nack <= 1'b1;
                        if (r_nackRun < NW'(NACK_LIMIT)) begin
                            r_nackRun <= r_nackRun + 1'b1;
                        end
                        if (r_nackRun >= NW'(NACK_LIMIT - 1)) begin
                            r_linkErr <= 1'b1;
                        end
                    end
                    if (w_push) begin
                        r_expectedSeq <= ~r_expectedSeq;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    r_ack   <= 1'b0;
                    r_nack  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_nack  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign nack     = r_nack;
    assign link_err = r_linkErr;

    arq_rx_fifo #(
        .DATA_W    (DATA_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_data  (r_data),
        .i_pop   (dout_ready),
        .o_data  (dout),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign dout_valid = ~w_empty;

`ifdef ARQ_RX_STATS_EN
    logic [7:0] r_goodCnt;
    logic [7:0] r_nackCnt;

    // Saturating counts of new frames pushed and nacks issued; duplicates count in neither.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_goodCnt <= '0;
            r_nackCnt <= '0;
        end else begin
            if (w_push && r_goodCnt != 8'hFF) begin
                r_goodCnt <= r_goodCnt + 1'b1;
            end
            if (w_respCode == RESP_NACK && r_nackCnt != 8'hFF) begin
                r_nackCnt <= r_nackCnt + 1'b1;
            end
        end
    end

    assign good_cnt = r_goodCnt;
    assign nack_cnt = r_nackCnt;
`endif

endmodule
